instr_fetch_ctrl: RTL

- Sequences the instruction memory for the IF stage.
- Owns the PC, issues word-aligned fetch requests, and buffers returned instructions in a small prefetch FIFO toward decode.
- Handles branch redirect/flush, and arbitrates the shared memory port between fetch and a program-loader write port.
- Sits between the byte-addressed, big-endian-packed 32-bit instruction memory and the IF/ID pipeline register.

---
 rtl/instr_fetch_ctrl_if.sv | 50 +++++
 rtl/instr_fetch_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl_if.sv
// rtl/instr_fetch_ctrl_if.sv - memory, redirect, decode and loader signal bundle for instr_fetch_ctrl
//
// Groups every non-clock/reset signal of the fetch controller.
//   master : the fetch controller (drives mem_*, instr_*, ld_done)
//   slave  : the surroundings (memory, EXE redirect, decode, program loader)
interface instr_fetch_ctrl_if #(
    parameter int INSTRUCTION_LEN = 32
);
    // Instruction memory port
    logic                       mem_req;
    logic                       mem_we;
    logic [INSTRUCTION_LEN-1:0] mem_addr;
    logic [INSTRUCTION_LEN-1:0] mem_wdata;
    logic                       mem_ready;
    logic [INSTRUCTION_LEN-1:0] mem_rdata;
    // Redirect and hazard control
    logic                       branch_taken;
    logic [INSTRUCTION_LEN-1:0] branch_target;
    logic                       freeze;
    // Toward decode
    logic                       instr_valid;
    logic [INSTRUCTION_LEN-1:0] instr;
    logic [INSTRUCTION_LEN-1:0] instr_pc;
    logic                       instr_ready;
    // Program loader
    logic                       ld_req;
    logic [INSTRUCTION_LEN-1:0] ld_addr;
    logic [INSTRUCTION_LEN-1:0] ld_wdata;
    logic                       ld_done;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata,
        input  branch_taken, branch_target, freeze,
        output instr_valid, instr, instr_pc,
        input  instr_ready,
        input  ld_req, ld_addr, ld_wdata,
        output ld_done
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata,
        output branch_taken, branch_target, freeze,
        input  instr_valid, instr, instr_pc,
        output instr_ready,
        output ld_req, ld_addr, ld_wdata,
        input  ld_done
    );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - IF-stage PC owner, fetch sequencer, prefetch FIFO and loader arbiter
//
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : instr_fetch_ctrl_if.master (memory port, branch/freeze, decode handshake, loader)
module instr_fetch_ctrl #(
    parameter int                         INSTRUCTION_LEN = 32,
    parameter int                         FIFO_DEPTH      = 2,
    parameter logic [INSTRUCTION_LEN-1:0] RESET_PC        = '0
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_ctrl_if.master bus
);
    localparam int W     = INSTRUCTION_LEN;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [W-1:0] ADDR_MASK = ~W'(3);

    typedef enum logic [1:0] {IDLE, FETCH, LOAD} state_e;

    state_e             state_q, state_d;
    logic [W-1:0]       pc_q, pc_d;
    logic [W-1:0]       mem_addr_q, mem_addr_d;
    logic [W-1:0]       mem_wdata_q, mem_wdata_d;
    logic               mem_we_q, mem_we_d;
    logic               discard_q, discard_d;
    logic [W-1:0]       fifo_instr_q [FIFO_DEPTH];
    logic [W-1:0]       fifo_instr_d [FIFO_DEPTH];
    logic [W-1:0]       fifo_pc_q [FIFO_DEPTH];
    logic [W-1:0]       fifo_pc_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [W-1:0]       hold_instr_q, hold_instr_d;
    logic [W-1:0]       hold_pc_q, hold_pc_d;

    logic               push, pop, head_valid, fifo_full, ld_done;
    logic [W-1:0]       head_instr, head_pc;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = mem_we_q;
        discard_d    = discard_q;
        fifo_instr_d = fifo_instr_q;
        fifo_pc_d    = fifo_pc_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        push         = 1'b0;
        ld_done      = 1'b0;

        head_valid = (count_q != '0);
        fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
        head_instr = head_valid ? fifo_instr_q[rd_ptr_q] : hold_instr_q;
        head_pc    = head_valid ? fifo_pc_q[rd_ptr_q]    : hold_pc_q;
        // Flush wins over a same-cycle decode pop.
        pop        = head_valid && bus.instr_ready && !bus.branch_taken;

        hold_instr_d = head_instr;
        hold_pc_d    = head_pc;

        case (state_q)
            IDLE: begin
                if (bus.ld_req) begin
                    state_d     = LOAD;
                    mem_addr_d  = bus.ld_addr & ADDR_MASK;
                    mem_wdata_d = bus.ld_wdata;
                    mem_we_d    = 1'b1;
                end else if (!bus.freeze && !fifo_full && !bus.branch_taken) begin
                    // Issue is held off during a redirect cycle so the old PC
                    // is never fetched; the new PC is used one cycle later.
                    state_d    = FETCH;
                    mem_addr_d = pc_q;
                    mem_we_d   = 1'b0;
                end
            end
            FETCH: begin
                if (bus.mem_ready) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                    if (!discard_q && !bus.branch_taken) begin
                        push = 1'b1;
                        pc_d = mem_addr_q + W'(4);
                    end
                end else if (bus.branch_taken) begin
                    // Response still in flight belongs to the old path.
                    discard_d = 1'b1;
                end
            end
            LOAD: begin
                if (bus.mem_ready) begin
                    state_d = IDLE;
                    ld_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.branch_taken) begin
            pc_d     = bus.branch_target & ADDR_MASK;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fifo_instr_d[wr_ptr_q] = bus.mem_rdata;
                fifo_pc_d[wr_ptr_q]    = mem_addr_q;
                wr_ptr_d               = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            discard_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            discard_q    <= discard_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            fifo_instr_q <= fifo_instr_d;
            fifo_pc_q    <= fifo_pc_d;
        end
    end

    assign bus.mem_req     = (state_q != IDLE);
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.instr_valid = head_valid;
    assign bus.instr       = head_instr;
    assign bus.instr_pc    = head_pc;
    assign bus.ld_done     = ld_done;
endmodule
